// File: rtl/dmem_pipe.sv
// Pipelined data memory: valid/ready requests, byte-lane stores, RD_LAT-deep response path.
// Build option DMEM_INIT_EN adds a post-reset hardware clear of the whole array.
module dmem_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_W-1:0]     req_addr_i,
    input  logic [DATA_W/8-1:0]   req_mask_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_W-1:0]     rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  init_busy_o
);

    localparam int NB    = DATA_W / 8;
    localparam int OFS   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                ready_q;
    logic                accept_s;
    logic                err_s;
    logic                wr_en_s;
    logic                rd_en_s;
    logic [ADDR_W-1:0]   idx_full_s;
    logic [IDX_W-1:0]    idx_s;
    logic                init_wr_s;
    logic [IDX_W-1:0]    ctr_q;

    // Request decode: upper address bits are not masked, so anything past DEPTH is an error
    always_comb begin
        accept_s   = req_valid_i & ready_q;
        idx_full_s = req_addr_i >> OFS;
        idx_s      = idx_full_s[IDX_W-1:0];
        err_s      = (req_addr_i[OFS-1:0] != {OFS{1'b0}}) | (idx_full_s >= ADDR_W'(DEPTH));
        wr_en_s    = accept_s & req_we_i & ~err_s;
        rd_en_s    = accept_s & ~req_we_i & ~err_s;
    end

`ifdef DMEM_INIT_EN
    logic [IDX_W-1:0] ctr_d;
    logic             busy_q;

    // Next-state logic: walk the clear counter across every word, then open for requests
    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        init_wr_s = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_wr_s = 1'b1;
                if (ctr_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                    ctr_d   = {IDX_W{1'b0}};
                end else begin
                    ctr_d   = ctr_q + IDX_W'(1);
                end
            end
            ST_READY: begin
                state_d = ST_READY;
            end
            default: begin
                state_d = ST_INIT;
                ctr_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // State, clear counter and registered handshake/status outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            ctr_q   <= {IDX_W{1'b0}};
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            ready_q <= (state_d == ST_READY);
            busy_q  <= (state_d == ST_INIT);
        end
    end

    assign init_busy_o = busy_q;
`else
    assign init_wr_s = 1'b0;
    assign ctr_q     = {IDX_W{1'b0}};

    // Next-state logic: without the clear there is only the serving state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_READY;
        endcase
    end

    // State and registered ready; ready rises on the first edge after reset release
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_READY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ST_READY);
        end
    end

    assign init_busy_o = 1'b0;
`endif

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Array port: clear or byte-lane write, plus synchronous read at the accept edge
    always_ff @(posedge clk_i) begin
        if (init_wr_s) begin
            mem_q[ctr_q] <= {DATA_W{1'b0}};
        end else if (wr_en_s) begin
            for (int b = 0; b < NB; b++) begin
                if (req_mask_i[b]) begin
                    mem_q[idx_s][8*b +: 8] <= req_wdata_i[8*b +: 8];
                end
            end
        end
        if (rd_en_s) begin
            rd_data_q <= mem_q[idx_s];
        end
    end

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] err_q;
    logic              ld_q;
    logic [DATA_W-1:0] stg_dat_s [RD_LAT];

    // Response valid/error shift register; reset discards everything in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= {RD_LAT{1'b0}};
            err_q <= {RD_LAT{1'b0}};
            ld_q  <= 1'b0;
        end else begin
            vld_q[0] <= accept_s;
            err_q[0] <= accept_s & err_s;
            ld_q     <= rd_en_s;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_q[k] <= vld_q[k-1];
                err_q[k] <= err_q[k-1];
            end
        end
    end

    // Stores and errored loads leave ld_q low, so their data lane reads as zero
    assign stg_dat_s[0] = ld_q ? rd_data_q : {DATA_W{1'b0}};

    for (genvar k = 1; k < RD_LAT; k++) begin : g_stg
        logic [DATA_W-1:0] dat_q;

        // Extra data stage for longer read latencies
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                dat_q <= {DATA_W{1'b0}};
            end else begin
                dat_q <= stg_dat_s[k-1];
            end
        end

        assign stg_dat_s[k] = dat_q;
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = vld_q[RD_LAT-1];
    assign rsp_err_o   = err_q[RD_LAT-1];
    assign rsp_rdata_o = stg_dat_s[RD_LAT-1];

endmodule

// File: tb/tb_dmem_pipe.sv
// Directed bench for dmem_pipe: three instances (RD_LAT 1, 2, 3) share one request stream.
// Init-clear expectations follow whether DMEM_INIT_EN is defined for the build.
module tb_dmem_pipe;

`ifdef DMEM_INIT_EN
    localparam int  EXP_N    = 1024;
    localparam logic EXP_BUSY = 1'b1;
`else
    localparam int  EXP_N    = 1;
    localparam logic EXP_BUSY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [3:0]  req_mask = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [2:0]  req_ready_s;
    logic [2:0]  rsp_valid_s;
    logic [2:0]  rsp_err_s;
    logic [2:0]  init_busy_s;
    logic [31:0] rsp_rdata_s [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_pipe #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .RD_LAT(1)) u_l1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready_s[0]),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_mask_i(req_mask), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_s[0]), .rsp_rdata_o(rsp_rdata_s[0]), .rsp_err_o(rsp_err_s[0]),
        .init_busy_o(init_busy_s[0]));

    dmem_pipe #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .RD_LAT(2)) u_l2 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready_s[1]),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_mask_i(req_mask), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_s[1]), .rsp_rdata_o(rsp_rdata_s[1]), .rsp_err_o(rsp_err_s[1]),
        .init_busy_o(init_busy_s[1]));

    dmem_pipe #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .RD_LAT(3)) u_l3 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready_s[2]),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_mask_i(req_mask), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid_s[2]), .rsp_rdata_o(rsp_rdata_s[2]), .rsp_err_o(rsp_err_s[2]),
        .init_busy_o(init_busy_s[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // One isolated request; checks that each instance answers exactly RD_LAT cycles later
    task automatic single(input string tag, input logic we, input logic [31:0] addr,
                          input logic [3:0] mask, input logic [31:0] wd,
                          input logic [31:0] want_d, input logic want_e);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_mask = mask; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("%s vld L%0d t%0d", tag, i + 1, k), {31'b0, rsp_valid_s[i]}, {31'b0, i == k});
                if (i == k) begin
                    chk($sformatf("%s data L%0d", tag, i + 1), rsp_rdata_s[i], want_d);
                    chk($sformatf("%s err L%0d", tag, i + 1), {31'b0, rsp_err_s[i]}, {31'b0, want_e});
                end
            end
        end
    endtask

    // Count edges after reset release until ready; busy must hold and no response may appear
    task automatic wait_ready(input string tag);
        int n = 0;
        bit busy_bad = 1'b0;
        bit stale = 1'b0;
        while (req_ready_s[0] !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
            if (req_ready_s[0] !== 1'b1 && init_busy_s != 3'b111) busy_bad = 1'b1;
            if (rsp_valid_s != 3'b000) stale = 1'b1;
        end
        chk({tag, " ready cycles"}, n, EXP_N);
        chk({tag, " busy during init"}, {31'b0, busy_bad}, 32'd0);
        chk({tag, " no stale rsp"}, {31'b0, stale}, 32'd0);
        chk({tag, " ready all"}, {29'b0, req_ready_s}, 32'd7);
        chk({tag, " busy low"}, {29'b0, init_busy_s}, 32'd0);
    endtask

    logic [2:0]  bv [6];
    logic [31:0] bd [3][6];

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst ready", {29'b0, req_ready_s}, 32'd0);
        chk("rst valid", {29'b0, rsp_valid_s}, 32'd0);
        chk("rst err", {29'b0, rsp_err_s}, 32'd0);
        chk("rst rdata L3", rsp_rdata_s[2], 32'd0);
        chk("rst busy", {31'b0, init_busy_s[0]}, {31'b0, EXP_BUSY});
        rst = 1'b0;
        wait_ready("init");

`ifdef DMEM_INIT_EN
        single("init ld ffc", 1'b0, 32'h0000_0FFC, 4'h0, 32'h0, 32'h0000_0000, 1'b0);
`endif
        single("st full", 1'b1, 32'h10, 4'hF, 32'hAABB_CCDD, 32'h0, 1'b0);
        single("st mask5", 1'b1, 32'h10, 4'h5, 32'h1122_3344, 32'h0, 1'b0);
        single("ld 10", 1'b0, 32'h10, 4'h0, 32'h0, 32'hAA22_CC44, 1'b0);

        for (int j = 0; j < 4; j++) begin
            single($sformatf("pre %0d", j), 1'b1, 32'(4 * j), 4'hF, 32'(j + 1), 32'h0, 1'b0);
        end
        single("st mask0", 1'b1, 32'h4, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            if (t < 4) begin
                req_valid = 1'b1; req_we = 1'b0; req_addr = 32'(4 * t);
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            bv[t] = rsp_valid_s;
            for (int i = 0; i < 3; i++) bd[i][t] = rsp_rdata_s[i];
        end
        req_valid = 1'b0;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("b2b vld L%0d t%0d", i + 1, t), {31'b0, bv[t][i]}, {31'b0, t >= i && t <= i + 3});
                if (t >= i && t <= i + 3) begin
                    chk($sformatf("b2b data L%0d t%0d", i + 1, t), bd[i][t], 32'(t - i + 1));
                end
            end
        end

        single("ld misalign", 1'b0, 32'h02, 4'h0, 32'h0, 32'h0, 1'b1);
        single("st range", 1'b1, 32'h1000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1);
        single("ld range", 1'b0, 32'h1000, 4'h0, 32'h0, 32'h0, 1'b1);
        single("ld 0 after err", 1'b0, 32'h0, 4'h0, 32'h0, 32'h1, 1'b0);
        single("st last", 1'b1, 32'hFFC, 4'hF, 32'h5A5A_0FFC, 32'h0, 1'b0);
        single("ld last", 1'b0, 32'hFFC, 4'h0, 32'h0, 32'h5A5A_0FFC, 1'b0);

        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_mask = 4'hF; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("adj vld L%0d", k + 1), {31'b0, rsp_valid_s[k]}, 32'd1);
            chk($sformatf("adj data L%0d", k + 1), rsp_rdata_s[k], 32'hDEAD_BEEF);
        end
        @(negedge clk);

        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre-rst vld L2", {31'b0, rsp_valid_s[1]}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid-rst vld", {29'b0, rsp_valid_s}, 32'd0);
        chk("mid-rst data L2", rsp_rdata_s[1], 32'd0);
        chk("mid-rst ready", {29'b0, req_ready_s}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_ready("reinit");
`ifdef DMEM_INIT_EN
        single("reinit ld 20", 1'b0, 32'h20, 4'h0, 32'h0, 32'h0, 1'b0);
        single("reinit ld 0", 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0);
`endif
        single("post-rst st", 1'b1, 32'h8, 4'hF, 32'h1234_5678, 32'h0, 1'b0);
        single("post-rst ld", 1'b0, 32'h8, 4'h0, 32'h0, 32'h1234_5678, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
